// File: rtl/accelerator_sort_pkg.sv
// Shared types and constants for the indexed usage sorter.
//   state_t : controller states (IDLE -> LOAD -> SORT -> EMIT -> IDLE)
//   pair_t  : one buffer slot, a usage value together with its original index.
//             Both fields are PAIR_WIDTH wide. The sorter compares and outputs
//             only the low DATA_SIZE bits, so DATA_SIZE must not exceed PAIR_WIDTH.
package accelerator_sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        EMIT = 2'd3
    } state_t;

    localparam logic ZERO = 1'b0;
    localparam logic ONE  = 1'b1;

    localparam int PAIR_WIDTH = 64;

    typedef struct packed {
        logic [PAIR_WIDTH-1:0] value;
        logic [PAIR_WIDTH-1:0] index;
    } pair_t;

endpackage

// File: rtl/accelerator_sort_compare_exchange.sv
// Combinational compare-exchange cell for odd-even transposition sorting.
//   a, b   : pairs currently held in adjacent slots (a is the lower slot)
//   enable : the cell is active in this pass
//   lo, hi : pairs to write back to the lower and upper slot
// The cell swaps only on a strict order violation. Equal values are never
// exchanged, so the lower original index stays first and the sort is stable.
module accelerator_sort_compare_exchange
    import accelerator_sort_pkg::*;
#(
    parameter int DATA_SIZE  = 64,
    parameter int DESCENDING = 0
) (
    input  pair_t a,
    input  pair_t b,
    input  logic  enable,
    output pair_t lo,
    output pair_t hi
);

    logic [DATA_SIZE-1:0] a_value;
    logic [DATA_SIZE-1:0] b_value;
    logic                 violation;
    logic                 swap;

    assign a_value   = a.value[DATA_SIZE-1:0];
    assign b_value   = b.value[DATA_SIZE-1:0];
    assign violation = (DESCENDING != 0) ? (a_value < b_value) : (a_value > b_value);
    assign swap      = enable && violation;

    assign lo = swap ? b : a;
    assign hi = swap ? a : b;

endmodule

// File: rtl/accelerator_sort_vector_indexed.sv
// Indexed usage sorter for DNC allocation. It returns phi, the original
// indices of the usage vector in usage order.
//   CLK / RST          : clock, asynchronous active-low reset
//   START / SIZE_N_IN  : begin a job of length min(SIZE_N_IN, MAX_N)
//   READY / BUSY       : one-cycle completion pulse / job in progress
//   SIZE_ERROR         : the requested length was clamped to MAX_N
//   U_IN_ENABLE / U_IN : usage words, accepted only while loading
//   U_OUT(_ENABLE)     : sorted usage values, registered
//   PHI_OUT(_ENABLE)   : original index of each U_OUT, zero-extended
// The job loads n words, runs n odd-even transposition passes (one per cycle)
// across MAX_N-1 compare-exchange cells, then streams the slots in order.
module accelerator_sort_vector_indexed
    import accelerator_sort_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int MAX_N        = 16,
    parameter int DESCENDING   = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 BUSY,
    output logic                 SIZE_ERROR,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic                 U_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] U_IN,
    output logic                 U_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] U_OUT,
    output logic                 PHI_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] PHI_OUT
);

    localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    state_t                  state;
    state_t                  state_next;
    logic [CONTROL_SIZE-1:0] n;
    logic [CONTROL_SIZE-1:0] cnt;     // load slot, pass number or emit slot
    logic [CONTROL_SIZE-1:0] n_req;
    logic                    size_over;
    logic                    last_cnt;
    logic                    emit_done;

    logic accept, load_wr, sort_step, emit_valid, finish;

    pair_t slots  [MAX_N];
    pair_t sorted [MAX_N];
    pair_t ce_lo  [MAX_N-1];
    pair_t ce_hi  [MAX_N-1];
    logic  ce_en  [MAX_N-1];
    pair_t emit_pair;

    assign size_over = SIZE_N_IN > DATA_SIZE'(MAX_N);
    assign n_req     = size_over ? CONTROL_SIZE'(MAX_N) : CONTROL_SIZE'(SIZE_N_IN);
    assign last_cnt  = (cnt == n - CONTROL_SIZE'(1));
    assign emit_done = (cnt == n);
    assign emit_pair = slots[cnt[IDX_W-1:0]];

    // Controller state register.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples values from before the clock edge.
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic. A zero-length job skips straight to EMIT, where it
    // finishes at once and produces READY on the following edge.
    always_comb begin
        // NOTE: default first, so an unlisted path cannot infer a latch.
        state_next = state;
        case (state)
            IDLE: if (START) state_next = (n_req == '0) ? EMIT : LOAD;
            LOAD: if (U_IN_ENABLE && last_cnt) state_next = SORT;
            SORT: if (last_cnt) state_next = EMIT;
            EMIT: if (emit_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded control actions for the datapath.
    always_comb begin
        accept     = ZERO;
        load_wr    = ZERO;
        sort_step  = ZERO;
        emit_valid = ZERO;
        finish     = ZERO;
        case (state)
            IDLE: accept    = START;
            LOAD: load_wr   = U_IN_ENABLE;
            SORT: sort_step = ONE;
            EMIT: begin
                emit_valid = !emit_done;
                finish     = emit_done;
            end
            default: ;
        endcase
    end

    // Compare-exchange network. The pass parity picks even or odd cells, and
    // cells that reach slot n or beyond are masked.
    for (genvar i = 0; i < MAX_N - 1; i++) begin : g_ce
        assign ce_en[i] = sort_step && (cnt[0] == 1'(i % 2)) && (CONTROL_SIZE'(i + 1) < n);
        accelerator_sort_compare_exchange #(
            .DATA_SIZE  (DATA_SIZE),
            .DESCENDING (DESCENDING)
        ) u_ce (
            .a      (slots[i]),
            .b      (slots[i+1]),
            .enable (ce_en[i]),
            .lo     (ce_lo[i]),
            .hi     (ce_hi[i])
        );
    end

    // Each slot is the lower input of the cell of its own parity, or the upper
    // input of the cell below it. Disabled cells pass their inputs through.
    for (genvar j = 0; j < MAX_N; j++) begin : g_slot
        if (j == 0) begin : g_first
            assign sorted[j] = (cnt[0] == ZERO) ? ce_lo[j] : slots[j];
        end else if (j == MAX_N - 1) begin : g_last
            assign sorted[j] = (cnt[0] == 1'((j - 1) % 2)) ? ce_hi[j-1] : slots[j];
        end else begin : g_mid
            assign sorted[j] = (cnt[0] == 1'(j % 2)) ? ce_lo[j] : ce_hi[j-1];
        end
    end

    // Datapath: job registers, slot buffer and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            n              <= '0;
            cnt            <= '0;
            READY          <= ZERO;
            BUSY           <= ZERO;
            SIZE_ERROR     <= ZERO;
            U_OUT_ENABLE   <= ZERO;
            PHI_OUT_ENABLE <= ZERO;
            U_OUT          <= '0;
            PHI_OUT        <= '0;
            // NOTE: the slot buffer is cleared on reset as well, so nothing from
            // an aborted job can reappear after reset.
            for (int j = 0; j < MAX_N; j++) slots[j] <= '0;
        end else begin
            READY          <= finish;
            U_OUT_ENABLE   <= emit_valid;
            PHI_OUT_ENABLE <= emit_valid;

            if (accept) begin
                n          <= n_req;
                BUSY       <= ONE;
                SIZE_ERROR <= size_over;
            end else if (finish) begin
                BUSY <= ZERO;
            end

            if (accept || finish)         cnt <= '0;
            else if (load_wr || sort_step) cnt <= last_cnt ? '0 : cnt + CONTROL_SIZE'(1);
            else if (emit_valid)           cnt <= cnt + CONTROL_SIZE'(1);

            for (int j = 0; j < MAX_N; j++) begin
                if (load_wr && (cnt == CONTROL_SIZE'(j)))
                    slots[j] <= '{value: PAIR_WIDTH'(U_IN), index: PAIR_WIDTH'(cnt)};
                else if (sort_step)
                    slots[j] <= sorted[j];
            end

            if (emit_valid) begin
                U_OUT   <= emit_pair.value[DATA_SIZE-1:0];
                PHI_OUT <= emit_pair.index[DATA_SIZE-1:0];
            end
        end
    end

endmodule
